// File: rtl/pipe_addsub_if.sv
// pipe_addsub_if: operand/result handshake bundle for the pipelined adder/subtractor
interface pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             ovf;
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, ovf
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// pipe_addsub: segmented-carry pipelined adder/subtractor with valid/ready backpressure
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  pipe_addsub_if.slave io
);
  localparam int SW = WIDTH / (STAGES < 1 ? 1 : STAGES);
  if (STAGES < 1 || WIDTH % (STAGES < 1 ? 1 : STAGES) != 0) begin : bad_params
    $fatal(1, "pipe_addsub: WIDTH must be a positive multiple of STAGES >= 1");
  end
  logic             adv;
  logic [WIDTH-1:0] bp;
  assign bp = io.sub ? ~io.b : io.b;
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * SW;
    logic                v;
    logic                c;
    logic [LO+SW-1:0]    r;
    logic [LO+SW-1:0]    rn;
    logic [WIDTH-LO-1:0] ai;
    logic [WIDTH-LO-1:0] bi;
    logic                ci;
    logic                vi;
    logic [SW:0]         s;
    if (k == 0) begin : src
      assign ai = io.a;
      assign bi = bp;
      assign ci = io.sub;
      assign vi = io.in_valid;
      assign rn = s[SW-1:0];
    end else begin : src
      assign ai = stg[k-1].sk.sa;
      assign bi = stg[k-1].sk.sb;
      assign ci = stg[k-1].c;
      assign vi = stg[k-1].v;
      assign rn = {s[SW-1:0], stg[k-1].r};
    end
    assign s = {1'b0, ai[SW-1:0]} + {1'b0, bi[SW-1:0]} + (SW+1)'(ci);
    // slice result joins the lower slices already computed; carry feeds the next stage
    always_ff @(posedge clk)
      if (rst) begin
        v <= 1'b0;
        c <= 1'b0;
        r <= '0;
      end else if (adv) begin
        v <= vi;
        c <= s[SW];
        r <= rn;
      end
    if (k < STAGES - 1) begin : sk
      logic [WIDTH-LO-SW-1:0] sa;
      logic [WIDTH-LO-SW-1:0] sb;
      // upper operand slices not yet consumed ride along to later stages
      always_ff @(posedge clk)
        if (rst) begin
          sa <= '0;
          sb <= '0;
        end else if (adv) begin
          sa <= ai[WIDTH-LO-1:SW];
          sb <= bi[WIDTH-LO-1:SW];
        end
    end
    if (k == STAGES - 1) begin : lst
      logic o;
      // the top slice holds both operand MSBs, so signed overflow is resolved here
      always_ff @(posedge clk)
        if (rst) o <= 1'b0;
        else if (adv) o <= (ai[SW-1] == bi[SW-1]) && (s[SW-1] != ai[SW-1]);
    end
  end
  assign adv          = !stg[STAGES-1].v || io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = stg[STAGES-1].v;
  assign io.sum       = {stg[STAGES-1].c, stg[STAGES-1].r};
  assign io.ovf       = stg[STAGES-1].lst.o;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed and random checks of pipe_addsub against a slot-level reference model
module tb_pipe_addsub;
  localparam int W = 8;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipe_addsub_if #(.WIDTH(W))  i8 ();
  pipe_addsub_if #(.WIDTH(32)) i32 ();
  pipe_addsub #(.WIDTH(W),  .STAGES(S)) u8  (.clk(clk), .rst(rst), .io(i8.slave));
  pipe_addsub #(.WIDTH(32), .STAGES(4)) u32 (.clk(clk), .rst(rst), .io(i32.slave));
  typedef struct packed {
    logic       v;
    logic [W:0] s;
    logic       o;
  } ent_t;
  ent_t pm [S];
  int nvec = 0;
  int nerr = 0;
  function automatic ent_t ref_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input bit sb);
    ent_t e;
    int u, rs;
    u  = sb ? (1 << W) + int'(aa) - int'(bb) : int'(aa) + int'(bb);
    rs = sb ? int'($signed(aa)) - int'($signed(bb)) : int'($signed(aa)) + int'($signed(bb));
    e.v = 1'b1;
    e.s = u[W:0];
    e.o = (rs > (1 << (W-1)) - 1) || (rs < -(1 << (W-1)));
    return e;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic compare();
    chk("in_ready", 64'(i8.in_ready), 64'(!pm[S-1].v || i8.out_ready));
    chk("out_valid", 64'(i8.out_valid), 64'(pm[S-1].v));
    if (pm[S-1].v) begin
      chk("sum", 64'(i8.sum), 64'(pm[S-1].s));
      chk("ovf", 64'(i8.ovf), 64'(pm[S-1].o));
    end
  endtask
  task automatic cyc(input bit iv, input logic [W-1:0] aa, input logic [W-1:0] bb,
                     input bit sb, input bit ordy, input bit r);
    compare();
    rst = r;
    i8.in_valid = iv;
    i8.a = aa;
    i8.b = bb;
    i8.sub = sb;
    i8.out_ready = ordy;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < S; k++) pm[k] = '0;
    end else if (!pm[S-1].v || ordy) begin
      for (int k = S - 1; k > 0; k--) pm[k] = pm[k-1];
      pm[0] = iv ? ref_op(aa, bb, sb) : '0;
    end
    @(negedge clk);
  endtask
  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb, input bit sb);
    cyc(1'b1, aa, bb, sb, 1'b1, 1'b0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
  endtask
  initial begin
    for (int k = 0; k < S; k++) pm[k] = '0;
    i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.sub = 1'b0; i8.out_ready = 1'b1;
    i32.in_valid = 1'b0; i32.a = '0; i32.b = '0; i32.sub = 1'b0; i32.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(i8.out_valid), 64'd0);
    chk("rst_sum", 64'(i8.sum), 64'd0);
    chk("rst_ovf", 64'(i8.ovf), 64'd0);
    chk("rst_in_ready", 64'(i8.in_ready), 64'd1);
    op(7, 9, 0); op(12, 24, 0); op(31, 1, 0); op(15, 11, 0);
    chk("basic_16", 64'(i8.sum), 64'd16);
    op(3, 4, 0);
    chk("basic_36", 64'(i8.sum), 64'd36);
    idle(1); chk("basic_32", 64'(i8.sum), 64'd32);
    idle(1); chk("basic_26", 64'(i8.sum), 64'd26);
    idle(1); chk("basic_7", 64'(i8.sum), 64'd7);
    idle(2);
    op(255, 1, 0); op(127, 1, 0); op(3, 4, 1); op(128, 1, 1);
    chk("ripple_sum", 64'(i8.sum), 64'h100); chk("ripple_ovf", 64'(i8.ovf), 64'd0);
    op(5, 5, 1);
    chk("p127_sum", 64'(i8.sum), 64'h080); chk("p127_ovf", 64'(i8.ovf), 64'd1);
    idle(1); chk("s3m4_sum", 64'(i8.sum), 64'h0FF); chk("s3m4_ovf", 64'(i8.ovf), 64'd0);
    idle(1); chk("s128m1_sum", 64'(i8.sum), 64'h17F); chk("s128m1_ovf", 64'(i8.ovf), 64'd1);
    idle(1); chk("s5m5_sum", 64'(i8.sum), 64'h100); chk("s5m5_ovf", 64'(i8.ovf), 64'd0);
    idle(2);
    for (int i = 0; i < 4; i++) op(W'(10 * i + 1), W'(i + 2), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'd50, 8'd60, 1'b0, 1'b0, 1'b0);
    chk("stall_in_ready", 64'(i8.in_ready), 64'd0);
    op(50, 60, 0); op(70, 80, 1);
    idle(6);
    for (int i = 0; i < 8; i++) cyc(i % 2 == 0, W'(i * 17), W'(i * 5), 1'b0, 1'b1, 1'b0);
    idle(5);
    op(100, 1, 0); op(101, 2, 0); op(102, 3, 1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("mid_rst_valid", 64'(i8.out_valid), 64'd0);
    chk("mid_rst_sum", 64'(i8.sum), 64'd0);
    idle(6);
    op(7, 9, 0);
    idle(3);
    chk("post_rst_valid", 64'(i8.out_valid), 64'd1);
    chk("post_rst_sum", 64'(i8.sum), 64'd16);
    idle(2);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, 1'b0);
    idle(8);
    i32.in_valid = 1'b1; i32.a = 32'hFFFF_FFFF; i32.b = 32'd1; i32.sub = 1'b0;
    idle(1);
    i32.a = 32'h8000_0000; i32.b = 32'd1; i32.sub = 1'b1;
    idle(1);
    i32.in_valid = 1'b0;
    idle(2);
    chk("w32_valid", 64'(i32.out_valid), 64'd1);
    chk("w32_ripple", 64'(i32.sum), 64'h1_0000_0000);
    chk("w32_ripple_ovf", 64'(i32.ovf), 64'd0);
    idle(1);
    chk("w32_sub", 64'(i32.sum), 64'h1_7FFF_FFFF);
    chk("w32_sub_ovf", 64'(i32.ovf), 64'd1);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
